case_3_sdiv_15s_8s_15_seq: RTL and testbench
============================================

# case_3_sdiv_15s_8s_15_seq

Iterative signed divider, the inverse operator of the 15s×8s→15 signed multiplier in the same datapath library. It computes a 15-bit signed quotient and an 8-bit signed remainder from a 15-bit signed dividend and an 8-bit signed divisor. It uses one restoring-division step per clock and an ap_start/ap_done block-level handshake. The kernel instantiates it where a `/` or `%` on these widths is scheduled as a multi-cycle operation.

## Interface
- din0_WIDTH, 15, dividend width (signed)
- din1_WIDTH, 8, divisor width (signed)
- dout_WIDTH, 15, quotient width (signed); remainder is din1_WIDTH bits
- ap_clk  in  1  clock, all state on rising edge
- ap_rst  in  1  reset, asynchronous, active-high
- ap_start  in  1  request; sampled only in IDLE
- ap_ready  out  1  one-cycle pulse when a start is accepted
- ap_idle  out  1  high in IDLE
- ap_done  out  1  one-cycle pulse, quot/rem valid
- din0  in  din0_WIDTH  dividend, captured on accepting start
- din1  in  din1_WIDTH  divisor, captured on accepting start
- quot  out  dout_WIDTH  quotient, held until next ap_done
- rem  out  din1_WIDTH  remainder, held until next ap_done
- div_by_zero  out  1  qualifies quot/rem at ap_done; held with them

## Operation
- States:
  - IDLE: accept a start; go to CALC.
  - CALC: din0_WIDTH iterations, step counter 0..din0_WIDTH-1; go to FIX.
  - FIX: sign correction, load outputs, pulse ap_done; go to IDLE.
- Accept (IDLE & ap_start):
  - latch |din0| and |din1| as unsigned magnitudes, one bit wider to hold |−2^(N−1)|;
  - latch quotient sign = din0[MSB]^din1[MSB] and remainder sign = din0[MSB];
  - latch zero-divisor flag;
  - clear the partial remainder; pulse ap_ready.
- CALC step, restoring algorithm:
  - r' = {r, next dividend bit MSB-first};
  - if r' ≥ |divisor|, then r = r' − |divisor| and the quotient bit is 1;
  - otherwise r = r' and the quotient bit is 0.
- FIX (C semantics):
  - quotient truncates toward zero; remainder takes the dividend's sign;
  - quot = qsign ? −q : q, truncated to dout_WIDTH. −16384 / −1 wraps to −16384; no overflow flag.
  - rem = rsign ? −r : r. Always |rem| ≤ 127, so it fits din1_WIDTH.
- Divide by zero:
  - same latency as a normal divide;
  - quot = all ones (−1), rem = din0[din1_WIDTH−1:0], div_by_zero = 1.
- ap_start while not IDLE: ignored, with no queueing.
- ap_start held high continuously: a new operation is accepted on the first IDLE cycle after each ap_done.

## Timing
- Start accepted at edge 0 (IDLE→CALC).
- CALC occupies din0_WIDTH cycles.
- FIX for one cycle; ap_done is high in the FIX cycle and outputs are registered at its end.
- Latency from the accepting edge to the ap_done cycle: din0_WIDTH+1 = 16 cycles.
- Throughput: one operation per din0_WIDTH+2 = 17 cycles.
- ap_ready is combinational from IDLE & ap_start. ap_idle is combinational from state. ap_done is registered.
- Reset values: state=IDLE, ap_ready=0, ap_done=0, ap_idle=1, quot=0, rem=0, div_by_zero=0, counter=0.
- Reset mid-operation:
  - immediate return to IDLE;
  - in-flight result discarded, no ap_done;
  - outputs cleared to 0.
- din0/din1 may change after acceptance without effect.

## Structure
- Shared package case_3_div_pkg:
  - state enum (IDLE, CALC, FIX);
  - localparam step-counter width = $clog2(din0_WIDTH+1);
  - sign-magnitude helper function abs_ext.
- One sub-module: case_3_sdiv_step, combinational shift/compare/subtract.
  - Inputs: partial remainder, incoming bit, divisor magnitude.
  - Outputs: next remainder and quotient bit.
- Top: FSM, counter, operand/sign registers and FIX logic.

## Test plan
- 100 / 7 → quot=14, rem=2, div_by_zero=0; ap_done exactly 16 cycles after the accepting edge.
- −100 / 7 → quot=−14, rem=−2; 100 / −7 → quot=−14, rem=2; −100 / −7 → quot=14, rem=−2.
- Extremes:
  - −16384 / −1 → quot=−16384 (wrap), rem=0;
  - −16384 / −128 → quot=128, rem=0;
  - 16383 / 127 → quot=129, rem=0.
- 55 / 0 → quot=−1, rem=55, div_by_zero=1, same latency. The next valid divide clears div_by_zero.
- ap_start held high with operands changing every cycle:
  - starts are accepted every 17 cycles; ap_ready pulses once per operation;
  - mid-operation starts are ignored; results match the operands at acceptance.
- ap_rst asserted 5 cycles into CALC:
  - asynchronous return to IDLE with outputs 0 and no ap_done;
  - a divide started after reset release (e.g. 100 / 7) completes correctly.

Source files
------------

// File: rtl/case_3_div_pkg.sv
// Shared definitions for the sequential signed divider: FSM encoding, counter
// width and the sign-magnitude helper.
package case_3_div_pkg;

  localparam int DIN0_W = 15;
  localparam int CNT_W  = $clog2(DIN0_W + 1);

  // State encoding
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  // Magnitude of a sign-extended two's-complement value; the extra headroom
  // holds |-2^(N-1)| for the narrower operands.
  function automatic logic [15:0] abs_ext(input logic [15:0] v);
    return v[15] ? (~v + 16'd1) : v;
  endfunction

endpackage

// File: rtl/case_3_sdiv_step.sv
// One restoring-division step: shift in a dividend bit, compare against the
// divisor magnitude and subtract when it fits.
module case_3_sdiv_step
  import case_3_div_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] r,
  input  logic         din,
  input  logic [W:0]   dmag,
  output logic [W-1:0] r_nxt,
  output logic         qbit
);

  logic [W:0] rp;

  assign rp    = {r, din};
  assign qbit  = (rp >= dmag);
  // A non-zero divisor keeps the result below dmag <= 2^(W-1), so W bits suffice.
  assign r_nxt = qbit ? W'(rp - dmag) : W'(rp);

endmodule

// File: rtl/case_3_sdiv_15s_8s_15_seq.sv
// Iterative 15s / 8s signed divider with C truncating semantics and an
// ap_start/ap_done handshake; one restoring step per clock.
module case_3_sdiv_15s_8s_15_seq
  import case_3_div_pkg::*;
#(
  parameter int din0_WIDTH = 15,
  parameter int din1_WIDTH = 8,
  parameter int dout_WIDTH = 15
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ap_start,
  output logic                  ap_ready,
  output logic                  ap_idle,
  output logic                  ap_done,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic [dout_WIDTH-1:0] quot,
  output logic [din1_WIDTH-1:0] rem,
  output logic                  div_by_zero
);

  logic [1:0]            state;
  logic [CNT_W-1:0]      cnt;
  // Dividend magnitude pre-shifted so its MSB feeds the step from the top bit;
  // quotient bits fill in from the bottom as the dividend shifts out.
  logic [din0_WIDTH:0]   dq;
  logic [din1_WIDTH:0]   dvs;
  logic [din1_WIDTH-1:0] r;
  logic [din1_WIDTH-1:0] r_nxt;
  logic [din1_WIDTH-1:0] zrem;
  logic                  qbit;
  logic                  qsign;
  logic                  rsign;
  logic                  zdiv;
  logic [din0_WIDTH-1:0] qmag;

  assign ap_idle  = (state == IDLE);
  assign ap_ready = ap_idle & ap_start;
  assign qmag     = dq[din0_WIDTH-1:0];

  case_3_sdiv_step #(
    .W (din1_WIDTH)
  ) u_step (
    .r     (r),
    .din   (dq[din0_WIDTH]),
    .dmag  (dvs),
    .r_nxt (r_nxt),
    .qbit  (qbit)
  );

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state       <= IDLE;
      cnt         <= '0;
      dq          <= '0;
      dvs         <= '0;
      r           <= '0;
      zrem        <= '0;
      qsign       <= 1'b0;
      rsign       <= 1'b0;
      zdiv        <= 1'b0;
      ap_done     <= 1'b0;
      quot        <= '0;
      rem         <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ap_done <= 1'b0;
          if (ap_start) begin
            dq    <= (din0_WIDTH+1)'(abs_ext(16'(signed'(din0))) << 1);
            dvs   <= (din1_WIDTH+1)'(abs_ext(16'(signed'(din1))));
            qsign <= din0[din0_WIDTH-1] ^ din1[din1_WIDTH-1];
            rsign <= din0[din0_WIDTH-1];
            zdiv  <= (din1 == '0);
            zrem  <= din0[din1_WIDTH-1:0];
            r     <= '0;
            cnt   <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          r  <= r_nxt;
          dq <= {dq[din0_WIDTH-1:0], qbit};
          if (cnt == CNT_W'(din0_WIDTH - 1)) begin
            cnt     <= '0;
            ap_done <= 1'b1;
            state   <= FIX;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FIX: begin
          ap_done <= 1'b0;
          state   <= IDLE;
          if (zdiv) begin
            quot        <= '1;
            rem         <= zrem;
            div_by_zero <= 1'b1;
          end else begin
            // Negation wraps naturally, so -16384 / -1 comes out as -16384.
            quot        <= qsign ? -qmag : qmag;
            rem         <= rsign ? -r : r;
            div_by_zero <= 1'b0;
          end
        end
        default: begin
          ap_done <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_case_3_sdiv_15s_8s_15_seq.sv
// Self-checking bench for the sequential signed divider against a C-semantics
// integer model.
module tb_case_3_sdiv_15s_8s_15_seq;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic        ap_start;
  logic        ap_ready;
  logic        ap_idle;
  logic        ap_done;
  logic [14:0] din0;
  logic [7:0]  din1;
  logic [14:0] quot;
  logic [7:0]  rem;
  logic        div_by_zero;

  int total = 0;
  int bad   = 0;

  always #5 ap_clk = ~ap_clk;

  case_3_sdiv_15s_8s_15_seq dut (
    .ap_clk      (ap_clk),
    .ap_rst      (ap_rst),
    .ap_start    (ap_start),
    .ap_ready    (ap_ready),
    .ap_idle     (ap_idle),
    .ap_done     (ap_done),
    .din0        (din0),
    .din1        (din1),
    .quot        (quot),
    .rem         (rem),
    .div_by_zero (div_by_zero)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // C semantics: truncate toward zero, remainder takes the dividend's sign.
  function automatic void ref_div(input logic [14:0] a, input logic [7:0] b,
                                  output logic [14:0] q, output logic [7:0] r,
                                  output logic z);
    int sa;
    int sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sb == 0) begin
      q = '1;
      r = a[7:0];
      z = 1'b1;
    end else begin
      q = 15'(sa / sb);
      r = 8'(sa % sb);
      z = 1'b0;
    end
  endfunction

  // Cycle 0 is the accept cycle; ap_done must be seen in cycle 16, results after it.
  task automatic run_div(input logic [14:0] a, input logic [7:0] b);
    logic [14:0] eq;
    logic [7:0]  er;
    logic        ez;
    int          cyc;
    bit          seen;
    ref_div(a, b, eq, er, ez);
    @(negedge ap_clk);
    din0 = a; din1 = b; ap_start = 1'b1;
    #1;
    check_eq("ready_pulse", ap_ready, 1);
    @(negedge ap_clk);
    ap_start = 1'b0;
    din0 = 15'($urandom); din1 = 8'($urandom);
    check_eq("ready_low", ap_ready, 0);
    cyc = 1; seen = 0;
    while (cyc < 40) begin
      if (ap_done) begin
        seen = 1;
        break;
      end
      @(negedge ap_clk);
      cyc++;
    end
    check_eq("done_seen", seen, 1);
    check_eq("latency", cyc, 16);
    @(negedge ap_clk);
    check_eq("done_pulse", ap_done, 0);
    check_eq("idle_after", ap_idle, 1);
    check_eq("quot", quot, eq);
    check_eq("rem", rem, er);
    check_eq("dbz", div_by_zero, ez);
  endtask

  logic [14:0] qq[$];
  logic [7:0]  rq[$];
  logic        zq[$];

  initial begin
    logic [14:0] eq;
    logic [7:0]  er;
    logic        ez;
    int          last_acc;
    int          nacc;
    int          ndone;
    bit          pend;
    bit          done_seen;

    ap_rst = 1'b1; ap_start = 1'b0; din0 = '0; din1 = '0;
    repeat (2) @(negedge ap_clk);
    check_eq("rst_idle", ap_idle, 1);
    check_eq("rst_ready", ap_ready, 0);
    check_eq("rst_done", ap_done, 0);
    check_eq("rst_quot", quot, 0);
    check_eq("rst_rem", rem, 0);
    check_eq("rst_dbz", div_by_zero, 0);
    ap_rst = 1'b0;

    // Directed cases
    run_div(15'd100, 8'd7);
    run_div(-15'sd100, 8'd7);
    run_div(15'd100, -8'sd7);
    run_div(-15'sd100, -8'sd7);
    run_div(15'h4000, 8'hFF);
    run_div(15'h4000, 8'h80);
    run_div(15'd16383, 8'd127);
    run_div(15'd55, 8'd0);
    run_div(15'd100, 8'd7);
    run_div(-15'sd300, 8'd0);

    // Random operands, occasionally a zero divisor
    for (int i = 0; i < 30; i++) begin
      run_div(15'($urandom), (i % 7 == 3) ? 8'd0 : 8'($urandom));
    end

    // ap_start held high with operands changing every cycle
    last_acc = -1; nacc = 0; ndone = 0; pend = 0;
    for (int c = 0; c < 90; c++) begin
      @(negedge ap_clk);
      ap_start = (c < 80);
      din0 = 15'($urandom); din1 = 8'($urandom);
      #1;
      if (pend) begin
        pend = 0;
        if (qq.size() > 0) begin
          check_eq("held_quot", quot, qq.pop_front());
          check_eq("held_rem", rem, rq.pop_front());
          check_eq("held_dbz", div_by_zero, zq.pop_front());
        end else begin
          check_eq("held_spurious_done", 1, 0);
        end
      end
      if (ap_done) begin
        pend = 1;
        ndone++;
      end
      if (ap_ready) begin
        ref_div(din0, din1, eq, er, ez);
        qq.push_back(eq); rq.push_back(er); zq.push_back(ez);
        if (last_acc >= 0) check_eq("held_period", c - last_acc, 17);
        last_acc = c;
        nacc++;
      end
    end
    check_eq("held_accepts", nacc, 5);
    check_eq("held_dones", ndone, 5);
    check_eq("held_drained", qq.size(), 0);

    // Reset five cycles into CALC
    @(negedge ap_clk);
    din0 = 15'd100; din1 = 8'd7; ap_start = 1'b1;
    @(negedge ap_clk);
    ap_start = 1'b0;
    repeat (5) @(negedge ap_clk);
    #2 ap_rst = 1'b1;
    #1;
    check_eq("mid_rst_idle", ap_idle, 1);
    check_eq("mid_rst_quot", quot, 0);
    check_eq("mid_rst_rem", rem, 0);
    check_eq("mid_rst_done", ap_done, 0);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    done_seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge ap_clk);
      if (ap_done) done_seen = 1;
    end
    check_eq("mid_rst_no_done", done_seen, 0);
    run_div(15'd100, 8'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
